// File: rtl/dequeue_shift_scheduler.sv
// dequeue_shift_scheduler
//   Round-robin arbiter sharing one downstream port among NumChan dequeue
//   shift registers. Only the granted channel gets its shift enable and
//   ready; its valid/data are muxed combinationally to the output. A grant
//   lasts until the source drains, or until MaxBurst handshakes have been
//   made while another channel is waiting. Every release costs one IDLE
//   cycle before the next grant.
//
// Ports
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en_i           : global enable; low gates shifting and freezes all state
//   cont_data_i    : per-channel request (shift register holds a message)
//   valid_i/data_i : per-channel output beat
//   ready_o        : per-channel ready (ready_i routed to granted channel)
//   shift_en_o     : per-channel shift enable (en_i routed to granted channel)
//   valid_o/data_o : downstream beat
//   ready_i        : downstream ready
//   chan_o         : granted channel index
//   busy_o         : high while a grant is active
module dequeue_shift_scheduler #(
  parameter int  NumChan  = 4,
  parameter int  MaxBurst = 4,
  parameter type data_t   = logic [31:0],
  localparam int IdxW     = $clog2(NumChan),
  localparam int CntW     = $clog2(MaxBurst + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [NumChan-1:0]       cont_data_i,
  input  logic [NumChan-1:0]       valid_i,
  input  data_t [NumChan-1:0]      data_i,
  output logic [NumChan-1:0]       ready_o,
  output logic [NumChan-1:0]       shift_en_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output data_t                    data_o,
  output logic [IdxW-1:0]          chan_o,
  output logic                     busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [CntW-1:0] burst_q, burst_d;

  logic               pick_vld;
  logic [IdxW-1:0]    pick_idx;
  logic [NumChan-1:0] grant_oh;
  logic               other_req;
  logic               hs;
  logic               blocked;
  logic               drained;
  logic               at_limit;
  logic [CntW-1:0]    burst_nx;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
    if (c == CntW'(MaxBurst)) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    if (i == IdxW'(NumChan - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Round-robin pick: first requesting channel starting at rr_q.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NumChan; i++) begin
      if (!pick_vld && cont_data_i[(int'(rr_q) + i) % NumChan]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'((int'(rr_q) + i) % NumChan);
      end
    end
  end

  always_comb begin
    grant_oh           = '0;
    grant_oh[grant_q]  = 1'b1;
    other_req          = |(cont_data_i & ~grant_oh);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    burst_d    = burst_q;
    valid_o    = 1'b0;
    ready_o    = '0;
    shift_en_o = '0;
    hs         = 1'b0;
    blocked    = 1'b0;
    drained    = 1'b0;
    at_limit   = 1'b0;
    burst_nx   = burst_q;

    case (state_q)
      IDLE: begin
        if (en_i && pick_vld) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        valid_o             = valid_i[grant_q];
        ready_o[grant_q]    = ready_i;
        shift_en_o[grant_q] = en_i;
        hs       = valid_o & ready_i;
        burst_nx = hs ? sat_inc(burst_q) : burst_q;
        drained  = ~cont_data_i[grant_q];
        // The limit counts this cycle's handshake, so the MaxBurst-th beat
        // itself triggers the rotation.
        at_limit = (burst_nx == CntW'(MaxBurst)) & other_req;
        // A presented beat must complete before the grant can move.
        blocked  = valid_o & ~ready_i;
        // With en_i low, beats still pass but all state is frozen.
        if (en_i) begin
          burst_d = burst_nx;
          if ((drained | at_limit) & ~blocked) begin
            state_d = IDLE;
            rr_d    = wrap_inc(grant_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o = data_i[grant_q];
  assign chan_o = grant_q;
  assign busy_o = (state_q == GRANT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: doc/dequeue_shift_scheduler.md
# dequeue_shift_scheduler

Round-robin scheduler that shares one downstream output port among `NumChan` dequeue shift registers, one per channel. It drives each channel's shift enable so that only the granted channel advances; all others freeze in place. It muxes the granted channel's valid/data to the output. The grant is held for up to `MaxBurst` output handshakes, then it rotates when another channel has pending data.

## Interface
- `NumChan`, default 4: number of channels; must be ≥ 2.
- `MaxBurst`, default 4: handshakes per grant before a forced rotation; must be ≥ 1.
- `data_t`, default `logic [31:0]`: payload type.
- `IdxW`, localparam = `$clog2(NumChan)`: channel index width.
- `CntW`, localparam = `$clog2(MaxBurst+1)`: burst counter width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: global enable. When low, all `shift_en_o` bits are 0; the grant and state are held.
- `cont_data_i`, in, NumChan: per channel, the shift register holds a loaded message. This is the request line.
- `valid_i`, in, NumChan: per-channel output valid.
- `data_i`, in, NumChan × data_t: per-channel output data.
- `ready_o`, out, NumChan: per-channel ready. Equal to `ready_i` for the granted channel in GRANT; 0 otherwise.
- `shift_en_o`, out, NumChan: per-channel shift enable. Equal to `en_i` for the granted channel in GRANT; 0 otherwise.
- `valid_o`, out, 1: downstream valid.
- `ready_i`, in, 1: downstream ready.
- `data_o`, out, data_t: downstream data.
- `chan_o`, out, IdxW: index of the granted channel.
- `busy_o`, out, 1: high while in GRANT.

## Operation
State machine with two states: IDLE and GRANT. Registers: `state_q`, `grant_q`, `rr_q` (next-priority pointer), `burst_q`.

- **IDLE**
  - All `ready_o`, `shift_en_o` = 0; `valid_o` = 0.
  - If any `cont_data_i` bit is set and `en_i` = 1: pick the first set bit scanning `rr_q`, `rr_q+1`, …, wrapping modulo NumChan.
  - On that pick: load `grant_q`, clear `burst_q`, go to GRANT.
- **GRANT**
  - `valid_o = valid_i[grant_q]`, `data_o = data_i[grant_q]`, combinational pass-through.
  - A handshake is `valid_o & ready_i`. Each handshake increments `burst_q`; `burst_q` saturates at MaxBurst.
- **Release from GRANT → IDLE** (with `rr_q ← (grant_q+1) mod NumChan`) happens when either condition holds:
  - `cont_data_i[grant_q]` = 0 (the source is drained), or
  - `burst_q` has reached MaxBurst, counting a handshake this cycle, and some other channel has `cont_data_i` set.
- **Release blocking:** release is suppressed in any cycle with `valid_o & ~ready_i`. A presented beat must be completed; valid never drops without a handshake.
- **Saturated burst, no competitor:** if `burst_q` = MaxBurst and no other channel requests, the grant is held and `burst_q` stays at MaxBurst.
- **Width and wrap rules:** `rr_q` wraps NumChan-1 → 0. `grant_q` is always < NumChan.
- **`en_i` = 0 in GRANT:** handshakes still pass through on `valid_o`/`ready_o`. Only shifting is gated.

## Timing
- **Reset values:**
  - Registers: `state_q` = IDLE, `grant_q` = 0, `rr_q` = 0, `burst_q` = 0.
  - Outputs: `valid_o` = 0, `ready_o` = 0, `shift_en_o` = 0, `chan_o` = 0, `busy_o` = 0, `data_o` = `data_i[0]`.
- **Reset mid-burst:** state returns to IDLE at the next edge; no output asserts in the following cycle.
- **Grant latency:** a request seen in IDLE at cycle N gives GRANT from cycle N+1.
- **Data path latency:** 0 cycles, combinational mux from `data_i`/`valid_i` to `data_o`/`valid_o`.
- **Release bubble:** every release costs one IDLE cycle, so the next grant is visible 2 cycles after the release-decision cycle.
- **Simultaneous release and new request:** the new request is arbitrated in the IDLE bubble using the updated `rr_q`.

## Test plan
- **Reset:** hold `rst_i` = 1 with all `cont_data_i` = 1 → all outputs 0. After deassert: IDLE 1 cycle, then `chan_o` = 0, `busy_o` = 1.
- **Single channel:** only channel 2 requests, 3 beats, `ready_i` = 1 → 3 handshakes with `data_o` equal to channel-2 data. `shift_en_o` = 4'b0100 throughout GRANT. Release when `cont_data_i[2]` falls; `rr_q` = 3.
- **Burst rotation:** NumChan = 4, MaxBurst = 4, channels 0 and 1 request continuously → channel 0 gets 4 handshakes, 1-cycle bubble, channel 1 gets 4, then back to channel 0.
- **Backpressure at limit:** 4th beat presented with `ready_i` = 0 for 5 cycles → grant held and `valid_o` held stable. Release occurs the cycle after `ready_i` rises.
- **Wrap-around:** `rr_q` = 3, channels 0 and 3 request → channel 3 granted first, then channel 0.
- **Enable gating:** `en_i` = 0 during GRANT → `shift_en_o` = 0 and the grant is held. Pending handshakes still complete when `valid_i` = `ready_i` = 1.
